// File: rtl/ula_pkg.sv
// Shared constants, size codes and state encoding for the ULA coprocessor controllers.
package ula_pkg;

  localparam int MAT_W   = 200;
  localparam int DATA_W  = 8;
  localparam int N_UNITS = 4;

  localparam logic [2:0] SZ1 = 3'd1;
  localparam logic [2:0] SZ2 = 3'd2;
  localparam logic [2:0] SZ3 = 3'd3;
  localparam logic [2:0] SZ4 = 3'd4;
  localparam logic [2:0] SZ5 = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, RESP} state_t;

  // Bit offset of element (r,c) in a row-major 5x5 matrix of bytes.
  function automatic int unsigned elem_off(input int unsigned r, input int unsigned c);
    return 40 * r + 8 * c;
  endfunction

endpackage

// File: rtl/ula_det_dispatcher_if.sv
// Command and response channels between a requester and the determinant dispatcher.
interface ula_det_dispatcher_if;
  import ula_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_size;
  logic [MAT_W-1:0]  cmd_matrix;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_det;
  logic              res_err;

  modport master (
    output cmd_valid, cmd_size, cmd_matrix, res_ready,
    input  cmd_ready, res_valid, res_det, res_err
  );

  modport slave (
    input  cmd_valid, cmd_size, cmd_matrix, res_ready,
    output cmd_ready, res_valid, res_det, res_err
  );

endinterface

// File: rtl/ula_timeout_ctr.sv
// 16-bit clearable saturating cycle counter; tc is high while the count sits at TERM.
module ula_timeout_ctr #(
  parameter logic [15:0] TERM = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [15:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != TERM) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/ula_det_dispatcher.sv
// Dispatches one determinant command at a time to the 2x2..5x5 units and returns the result.
module ula_det_dispatcher
  import ula_pkg::MAT_W, ula_pkg::N_UNITS, ula_pkg::elem_off,
         ula_pkg::SZ1, ula_pkg::SZ2, ula_pkg::SZ3, ula_pkg::SZ4, ula_pkg::SZ5,
         ula_pkg::state_t, ula_pkg::IDLE, ula_pkg::WAIT, ula_pkg::DRAIN, ula_pkg::RESP;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int DATA_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ula_det_dispatcher_if.slave       bus,
  output logic [MAT_W-1:0]          det_matrix,
  output logic [N_UNITS-1:0]        det_start,
  input  logic [N_UNITS-1:0]        det_done,
  input  logic [N_UNITS*DATA_W-1:0] det_result,
  output logic                      busy
);

  localparam int E00 = elem_off(0, 0);

  state_t            state, state_next;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] res_det_q, res_det_d, unit_res;
  logic              res_err_q, res_err_d;
  logic              accept, sel_done, ctr_clr, ctr_en, tc;

  assign bus.cmd_ready = rst_n && (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign sel_done      = det_done[sel_q];
  assign busy          = (state != IDLE);
  assign bus.res_valid = (state == RESP);
  assign bus.res_det   = res_det_q;
  assign bus.res_err   = res_err_q;
  assign ctr_en        = (state == WAIT) || (state == DRAIN);

  ula_timeout_ctr #(.TERM(16'(TIMEOUT_CYCLES - 1))) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (tc)
  );

  always_comb begin
    unit_res = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel_q == 2'(i)) unit_res = det_result[i*DATA_W +: DATA_W];
    end
  end

  // Start is decoded from the registered state so an asynchronous reset drops it at once.
  always_comb begin
    det_start = '0;
    if (state == WAIT) det_start[sel_q] = 1'b1;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
    state_next = state;
    ctr_clr    = 1'b0;
    res_det_d  = res_det_q;
    res_err_d  = res_err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_size == SZ1) begin
            res_det_d  = bus.cmd_matrix[E00 +: DATA_W];
            res_err_d  = 1'b0;
            state_next = RESP;
          end else if (bus.cmd_size inside {SZ2, SZ3, SZ4, SZ5}) begin
            res_det_d  = '0;
            res_err_d  = 1'b0;
            ctr_clr    = 1'b1;
            state_next = WAIT;
          end else begin
            res_det_d  = '0;
            res_err_d  = 1'b1;
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        // A done arriving in the terminal cycle still wins over the timeout.
        if (sel_done) begin
          res_det_d  = unit_res;
          res_err_d  = 1'b0;
          ctr_clr    = 1'b1;
          state_next = DRAIN;
        end else if (tc) begin
          res_det_d  = '0;
          res_err_d  = 1'b1;
          ctr_clr    = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!sel_done) begin
          state_next = RESP;
        end else if (tc) begin
          res_err_d  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: det_matrix is a plain register bank visible on a port, so it is reset like any other flop.
      det_matrix <= '0;
      sel_q      <= '0;
      res_det_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        det_matrix <= bus.cmd_matrix;
        sel_q      <= bus.cmd_size[1:0] - 2'd2;
      end
      res_det_q <= res_det_d;
      res_err_q <= res_err_d;
    end
  end

endmodule

// File: tb/tb_ula_det_dispatcher.sv
// Self-checking bench: stub determinant units, table vectors, hand sequences and a randomized model check.
module tb_ula_det_dispatcher;
  import ula_pkg::*;

  localparam int TO = 16;

  typedef enum int {NORMAL, NEVER, STICK} stub_mode_t;

  typedef struct {
    logic [2:0] size;
    stub_mode_t mode;
    int         delay;
    logic [7:0] res;
    logic [3:0] noise;
    logic [7:0] e00;
    bit         ident;
    logic [7:0] exp_det;
    logic       exp_err;
    logic [3:0] exp_start;
    int         exp_lat;
    int         exp_scnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ula_det_dispatcher_if bus();

  logic [MAT_W-1:0] det_matrix;
  logic [3:0]       det_start, det_done;
  logic [3:0]       stub_done = '0;
  logic [3:0]       noise = '0;
  logic [31:0]      det_result;
  logic             busy;

  logic [7:0] res_b [4];
  stub_mode_t mode  [4];
  int         delay [4];
  int         scnt  [4];

  int         checks = 0;
  int         errors = 0;
  logic [3:0] start_or = '0;
  int         start_cnt = 0;

  always #5 clk = ~clk;

  ula_det_dispatcher #(.TIMEOUT_CYCLES(TO), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .det_matrix (det_matrix),
    .det_start  (det_start),
    .det_done   (det_done),
    .det_result (det_result),
    .busy       (busy)
  );

  assign det_result = {res_b[3], res_b[2], res_b[1], res_b[0]};
  assign det_done   = stub_done | noise;

  // Stub units: done rises 'delay' cycles after start; NORMAL clears it once start is low, STICK never does.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (det_start[i]) begin
        scnt[i] <= scnt[i] + 1;
        if (mode[i] != NEVER && scnt[i] + 1 >= delay[i]) stub_done[i] <= 1'b1;
      end else begin
        scnt[i] <= 0;
        if (mode[i] != STICK) stub_done[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    start_or <= start_or | det_start;
    if (det_start != 4'b0000) start_cnt <= start_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < MAT_W; i += 8) m[i +: 8] = 8'($urandom);
    return m;
  endfunction

  // Reference: what the dispatcher must report for a command given how the selected unit behaves.
  function automatic void model(input logic [2:0] size, input logic [7:0] e00, input stub_mode_t md,
                                input int d, input logic [7:0] r,
                                output logic [7:0] det, output logic err, output logic [3:0] onehot);
    bit in_time;
    in_time = (md != NEVER) && (d <= TO - 1);
    onehot  = '0;
    if (size == 3'd1) begin
      det = e00;
      err = 1'b0;
    end else if (size >= 3'd2 && size <= 3'd5) begin
      onehot[int'(size) - 2] = 1'b1;
      det = in_time ? r : 8'h00;
      err = !in_time || (md == STICK);
    end else begin
      det = 8'h00;
      err = 1'b1;
    end
  endfunction

  task automatic setup_stub(input logic [2:0] size, input stub_mode_t md, input int d, input logic [7:0] r);
    for (int i = 0; i < 4; i++) begin
      mode[i]  = NORMAL;
      delay[i] = 1000;
      res_b[i] = 8'($urandom);
    end
    if (size >= 3'd2 && size <= 3'd5) begin
      mode[int'(size) - 2]  = md;
      delay[int'(size) - 2] = d;
      res_b[int'(size) - 2] = r;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) mode[i] = NORMAL;
    noise = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [2:0] size, input logic [MAT_W-1:0] m,
                        output logic seen, output logic [7:0] det, output logic err, output int lat,
                        output logic [MAT_W-1:0] mat_q, output logic [3:0] st_or, output int st_cnt,
                        output logic rv_after);
    int n;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_size   = size;
    bus.cmd_matrix = m;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_size   = 3'($urandom);
    bus.cmd_matrix = rand_mat();
    start_or  = '0;
    start_cnt = 0;
    lat  = 0;
    seen = 1'b0;
    mat_q = '0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) mat_q = det_matrix;
      seen = bus.res_valid;
    end
    det = bus.res_det;
    err = bus.res_err;
    @(posedge clk);
    #1;
    rv_after = bus.res_valid;
    st_or    = start_or;
    st_cnt   = start_cnt;
  endtask

  vec_t tbl [12];

  initial begin
    logic             seen, err, rv_after;
    logic [7:0]       det;
    int               lat, st_cnt, n;
    logic [MAT_W-1:0] m, mat_q;
    logic [3:0]       st_or;

    tbl[0]  = '{3'd3, NORMAL,  6, 8'h01, 4'h0, 8'h00, 1'b1, 8'h01, 1'b0, 4'b0010, 10,  7};
    tbl[1]  = '{3'd5, NORMAL,  3, 8'hF6, 4'h0, 8'h11, 1'b0, 8'hF6, 1'b0, 4'b1000, -1,  4};
    tbl[2]  = '{3'd1, NORMAL,  1, 8'h00, 4'h0, 8'h2A, 1'b0, 8'h2A, 1'b0, 4'b0000,  1,  0};
    tbl[3]  = '{3'd6, NORMAL,  1, 8'h00, 4'h0, 8'h33, 1'b0, 8'h00, 1'b1, 4'b0000,  1,  0};
    tbl[4]  = '{3'd0, NORMAL,  1, 8'h00, 4'hF, 8'h44, 1'b0, 8'h00, 1'b1, 4'b0000,  1,  0};
    tbl[5]  = '{3'd7, NORMAL,  1, 8'h00, 4'h0, 8'h55, 1'b0, 8'h00, 1'b1, 4'b0000,  1,  0};
    tbl[6]  = '{3'd2, NORMAL,  1, 8'h80, 4'h0, 8'h66, 1'b0, 8'h80, 1'b0, 4'b0001,  5,  2};
    tbl[7]  = '{3'd4, NEVER,   1, 8'hAB, 4'h0, 8'h77, 1'b0, 8'h00, 1'b1, 4'b0100, 18, 16};
    tbl[8]  = '{3'd4, STICK,   2, 8'h3C, 4'h0, 8'h88, 1'b0, 8'h3C, 1'b1, 4'b0100, 20,  3};
    tbl[9]  = '{3'd2, NORMAL, 15, 8'h5A, 4'hE, 8'h99, 1'b0, 8'h5A, 1'b0, 4'b0001, -1, 16};
    tbl[10] = '{3'd3, NORMAL, 16, 8'h77, 4'h0, 8'hAA, 1'b0, 8'h00, 1'b1, 4'b0010, 19, 16};
    tbl[11] = '{3'd5, STICK,  20, 8'h99, 4'h0, 8'hBB, 1'b0, 8'h00, 1'b1, 4'b1000, -1, 16};

    bus.cmd_valid  = 1'b0;
    bus.cmd_size   = '0;
    bus.cmd_matrix = '0;
    bus.res_ready  = 1'b1;
    setup_stub(3'd0, NORMAL, 1000, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cmd_ready",  64'(bus.cmd_ready), 64'(0));
    check("rst det_start",  64'(det_start),     64'(0));
    check("rst det_matrix", 64'(det_matrix != '0), 64'(0));
    check("rst res_valid",  64'(bus.res_valid), 64'(0));
    check("rst res_det",    64'(bus.res_det),   64'(0));
    check("rst res_err",    64'(bus.res_err),   64'(0));
    check("rst busy",       64'(busy),          64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Start falls the cycle after done is sampled
    setup_stub(3'd3, NORMAL, 6, 8'h01);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_size  = 3'd3;
    bus.cmd_matrix = rand_mat();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("seq start one-hot", 64'(det_start), 64'(4'b0010));
    n = 0;
    while (!det_done[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("seq done seen", 64'(det_done[1]), 64'(1));
    check("seq start with done", 64'(det_start), 64'(4'b0010));
    @(negedge clk);
    check("seq start after done", 64'(det_start), 64'(0));
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("seq res_valid", 64'(bus.res_valid), 64'(1));
    check("seq res_det",   64'(bus.res_det),   64'(8'h01));
    @(posedge clk);
    #1;
    settle();

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      setup_stub(tbl[i].size, tbl[i].mode, tbl[i].delay, tbl[i].res);
      noise = tbl[i].noise;
      m = rand_mat();
      if (tbl[i].ident) begin
        m = '0;
        for (int r = 0; r < 3; r++) m[elem_off(r, r) +: 8] = 8'h01;
      end
      m[7:0] = tbl[i].e00;
      do_cmd(tbl[i].size, m, seen, det, err, lat, mat_q, st_or, st_cnt, rv_after);
      check($sformatf("vec%0d res_valid seen", i), 64'(seen), 64'(1));
      check($sformatf("vec%0d res_det", i), 64'(det), 64'(tbl[i].exp_det));
      check($sformatf("vec%0d res_err", i), 64'(err), 64'(tbl[i].exp_err));
      check($sformatf("vec%0d det_start bits", i), 64'(st_or), 64'(tbl[i].exp_start));
      check($sformatf("vec%0d det_matrix", i), 64'(mat_q == m), 64'(1));
      check($sformatf("vec%0d single resp cycle", i), 64'(rv_after), 64'(0));
      if (tbl[i].exp_lat >= 0)
        check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      if (tbl[i].exp_scnt >= 0)
        check($sformatf("vec%0d start cycles", i), 64'(st_cnt), 64'(tbl[i].exp_scnt));
      settle();
    end

    // Illegal size, then a command held valid during RESP
    bus.res_ready = 1'b0;
    m = rand_mat();
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_size   = 3'd6;
    bus.cmd_matrix = m;
    @(posedge clk);
    #1;
    bus.cmd_size   = 3'd1;
    bus.cmd_matrix = rand_mat();
    bus.cmd_matrix[7:0] = 8'h55;
    @(negedge clk);
    check("hold res_valid T+1", 64'(bus.res_valid), 64'(1));
    check("hold res_err",       64'(bus.res_err),   64'(1));
    check("hold res_det",       64'(bus.res_det),   64'(0));
    repeat (3) @(negedge clk);
    check("hold cmd_ready",     64'(bus.cmd_ready), 64'(0));
    check("hold res_valid",     64'(bus.res_valid), 64'(1));
    check("hold matrix kept",   64'(det_matrix == m), 64'(1));
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("hold idle res_valid", 64'(bus.res_valid), 64'(0));
    check("hold idle cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("hold 2nd res_valid", 64'(bus.res_valid), 64'(1));
    check("hold 2nd res_det",   64'(bus.res_det),   64'(8'h55));
    check("hold 2nd res_err",   64'(bus.res_err),   64'(0));
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold 2nd released",  64'(bus.res_valid), 64'(0));
    settle();

    // Reset pulsed while a unit is running
    setup_stub(3'd4, NEVER, 1, 8'h00);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_size   = 3'd4;
    bus.cmd_matrix = rand_mat();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rstw start before", 64'(det_start), 64'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw start async",  64'(det_start),     64'(0));
    check("rstw busy",         64'(busy),          64'(0));
    check("rstw res_valid",    64'(bus.res_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    setup_stub(3'd2, NORMAL, 3, 8'hC3);
    m = rand_mat();
    do_cmd(3'd2, m, seen, det, err, lat, mat_q, st_or, st_cnt, rv_after);
    check("rstw post seen",  64'(seen),  64'(1));
    check("rstw post det",   64'(det),   64'(8'hC3));
    check("rstw post err",   64'(err),   64'(0));
    check("rstw post start", 64'(st_or), 64'(4'b0001));
    settle();

    // Randomized commands against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [2:0] size;
      stub_mode_t md;
      int         d, pick;
      logic [7:0] r, exp_det;
      logic       exp_err;
      logic [3:0] onehot;
      size = 3'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      md   = (pick < 7) ? NORMAL : ((pick == 7) ? NEVER : STICK);
      d    = int'($urandom_range(1, 20));
      r    = 8'($urandom);
      m    = rand_mat();
      model(size, m[7:0], md, d, r, exp_det, exp_err, onehot);
      setup_stub(size, md, d, r);
      noise = 4'($urandom) & ~onehot;
      do_cmd(size, m, seen, det, err, lat, mat_q, st_or, st_cnt, rv_after);
      check($sformatf("rnd%0d seen", k),   64'(seen),  64'(1));
      check($sformatf("rnd%0d det", k),    64'(det),   64'(exp_det));
      check($sformatf("rnd%0d err", k),    64'(err),   64'(exp_err));
      check($sformatf("rnd%0d start", k),  64'(st_or), 64'(onehot));
      check($sformatf("rnd%0d matrix", k), 64'(mat_q == m), 64'(1));
      check($sformatf("rnd%0d one resp", k), 64'(rv_after), 64'(0));
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_det_dispatcher.md
# ula_det_dispatcher

Command-level controller for the coprocessor ULA's determinant units (2x2, 3x3, 4x4, 5x5). It accepts one determinant command at a time over a valid/ready handshake and registers the 200-bit matrix onto a shared operand bus. It then drives the level-held start of the selected unit, captures its 8-bit result and returns it over a valid/ready response channel. Illegal sizes and hung units are reported through an error flag.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles spent in WAIT or DRAIN before an error is reported (range 1..65535).
- DATA_W, 8: element and result width.

Ports:
- clk, in, 1: single clock. One clock domain.
- rst_n, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: high only in IDLE.
- cmd_size, in, 3: matrix order. 1..5 are legal.
- cmd_matrix, in, 200: row-major matrix; element (r,c) is at [40r+8c +: 8]. Orders below 5 use the upper-left block.
- det_matrix, out, 200: registered operand bus, shared by all units.
- det_start, out, 4: one-hot level start; bit i selects unit of order i+2.
- det_done, in, 4: per-unit level done.
- det_result, in, 32: unit i result at [8i +: 8].
- res_valid, out, 1: response present.
- res_ready, in, 1: consumer accepts the response.
- res_det, out, 8: determinant, mod 256.
- res_err, out, 1: illegal size or timeout.
- busy, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, DRAIN, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_size and cmd_matrix into det_matrix.
  - Size 2..5: go to WAIT.
  - Size 1: res_det = cmd_matrix[7:0], res_err = 0, go to RESP.
  - Size 0, 6, 7: res_det = 0, res_err = 1, go to RESP. No unit is started.
- WAIT:
  - det_start[size-2] = 1; all other bits 0. The cycle counter is cleared on entry.
  - When det_done[size-2] is sampled high: capture det_result[8(size-2) +: 8] into res_det with res_err = 0, drop det_start, go to DRAIN.
  - If the counter reaches TIMEOUT_CYCLES first: res_det = 0, res_err = 1, drop det_start, go to DRAIN.
  - det_done bits of non-selected units are ignored.
- DRAIN:
  - det_start is all zero.
  - Wait for det_done[size-2] to read 0, then go to RESP. This guarantees a stale done cannot satisfy the next command.
  - The counter restarts on entry. On expiry, set res_err = 1, keep res_det, go to RESP.
- RESP:
  - res_valid = 1, with res_det and res_err stable.
  - On res_ready, go to IDLE and clear res_valid in the same edge.
- Only one unit is started per command; det_start is never multi-hot.
- Arithmetic: no arithmetic is performed here. Results pass through unchanged. The counter is 16 bits and saturates at the terminal count.

## Timing
- Reset values: cmd_ready = 0 while rst_n is low, then 1 in IDLE. det_start = 0, det_matrix = 0, res_valid = 0, res_det = 0, res_err = 0, busy = 0. State = IDLE.
- Reset mid-command drops det_start immediately (asynchronous). Any pending response is discarded.
- Accept at edge T: det_start is high from T+1.
- Done sampled high at edge D: det_start is low from D+1 and res_det is valid in the register from D+1.
- DRAIN lasts at least 1 cycle. With units that clear done one cycle after start falls, res_valid rises at D+2 or D+3.
- Size 1 or illegal size: res_valid is high from T+1.
- Response handshake: res_valid rises ≥1 cycle after accept. The earliest next command is accepted 1 cycle after res_valid && res_ready.
- Commands presented while busy are not accepted (cmd_ready = 0). cmd_matrix need only be stable in the accept cycle.
- res_ready held high continuously gives exactly 1 RESP cycle per command.

## Structure
- Shared package ula_pkg:
  - MAT_W = 200, DATA_W = 8, N_UNITS = 4.
  - Size-code constants SZ1..SZ5.
  - State enum {IDLE, WAIT, DRAIN, RESP}.
  - Element-offset function elem_off(r,c) = 40r + 8c.
- Sub-module ula_timeout_ctr: 16-bit clearable saturating counter with a terminal-count flag, reused by the other ULA controllers.
- All else is inline: FSM, one-hot decode, result mux.

## Test plan
- Size 3, identity matrix; stub unit raises done 6 cycles after start -> res_det = 8'h01, res_err = 0. Check: det_start = 4'b0010, det_start is 0 the cycle after done, and res_valid is high.
- Size 5 command; stub returns det_result[31:24] = 8'hF6 -> res_det = 8'hF6. No other det_start bit toggles at any point.
- Size 1, cmd_matrix[7:0] = 8'h2A -> res_valid at T+1 with res_det = 8'h2A; det_start stays 0.
- Size 6 -> res_err = 1, res_det = 0, res_valid at T+1. cmd_valid held during RESP is not accepted until res_ready is asserted.
- TIMEOUT_CYCLES = 16, stub never raises done -> det_start drops after 16 WAIT cycles, then res_err = 1. A stub whose done sticks high in DRAIN -> second timeout, res_err = 1, return to IDLE.
- rst_n pulsed low in WAIT -> det_start = 0 asynchronously and state = IDLE. After reset, a new size-2 command completes normally with res_valid and the correct res_det.
